// File: rtl/decode_fwd_stage_if.sv
// Decode/forwarding stage bus: D-stage fields, register-file read port,
// forwarding sources from E/M/W, downstream control and the E-stage register.
interface decode_fwd_stage_if #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 4
);
    logic                D_valid;
    logic [3:0]          D_icode;
    logic [3:0]          D_ifun;
    logic [DATA_WID-1:0] D_valC;
    logic [DATA_WID-1:0] D_valP;
    logic [ADDR_WID-1:0] D_srcA;
    logic [ADDR_WID-1:0] D_srcB;
    logic [ADDR_WID-1:0] D_dstE;
    logic [ADDR_WID-1:0] D_dstM;

    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [DATA_WID-1:0] rf_valA;
    logic [DATA_WID-1:0] rf_valB;

    logic [ADDR_WID-1:0] e_dstE;
    logic [DATA_WID-1:0] e_valE;
    logic [ADDR_WID-1:0] M_dstM;
    logic [DATA_WID-1:0] m_valM;
    logic [ADDR_WID-1:0] M_dstE;
    logic [DATA_WID-1:0] M_valE;
    logic [ADDR_WID-1:0] W_dstM;
    logic [DATA_WID-1:0] W_valM;
    logic [ADDR_WID-1:0] W_dstE;
    logic [DATA_WID-1:0] W_valE;

    logic                E_hold;
    logic                E_flush;
    logic                ld_use_stall;

    logic                E_valid;
    logic [3:0]          E_icode;
    logic [3:0]          E_ifun;
    logic [DATA_WID-1:0] E_valC;
    logic [DATA_WID-1:0] E_valA;
    logic [DATA_WID-1:0] E_valB;
    logic [ADDR_WID-1:0] E_dstE;
    logic [ADDR_WID-1:0] E_dstM;
    logic [ADDR_WID-1:0] E_srcA;
    logic [ADDR_WID-1:0] E_srcB;

    modport slave (
        input  D_valid, D_icode, D_ifun, D_valC, D_valP, D_srcA, D_srcB, D_dstE, D_dstM,
        output srcA, srcB,
        input  rf_valA, rf_valB,
        input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        input  W_dstM, W_valM, W_dstE, W_valE,
        input  E_hold, E_flush,
        output ld_use_stall,
        output E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport master (
        output D_valid, D_icode, D_ifun, D_valC, D_valP, D_srcA, D_srcB, D_dstE, D_dstM,
        input  srcA, srcB,
        output rf_valA, rf_valB,
        output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        output W_dstM, W_valM, W_dstE, W_valE,
        output E_hold, E_flush,
        input  ld_use_stall,
        input  E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_fwd_stage.sv
// Decode stage: operand forwarding, load-use stall detection and the D->E register.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.

// One operand's forwarding mux; fwdHit is set only when a pipeline stage supplied the value.
module decode_fwd_mux #(
    parameter int                  DATA_WID = 32,
    parameter int                  ADDR_WID = 4,
    parameter logic [ADDR_WID-1:0] RNONE    = 4'hF
) (
    input  logic                useValP,
    input  logic [DATA_WID-1:0] valP,
    input  logic [ADDR_WID-1:0] src,
    input  logic [DATA_WID-1:0] rfVal,
    input  logic [ADDR_WID-1:0] eDstE,
    input  logic [DATA_WID-1:0] eValE,
    input  logic [ADDR_WID-1:0] mDstM,
    input  logic [DATA_WID-1:0] mValM,
    input  logic [ADDR_WID-1:0] mDstE,
    input  logic [DATA_WID-1:0] mValE,
    input  logic [ADDR_WID-1:0] wDstM,
    input  logic [DATA_WID-1:0] wValM,
    input  logic [ADDR_WID-1:0] wDstE,
    input  logic [DATA_WID-1:0] wValE,
    output logic [DATA_WID-1:0] val,
    output logic                fwdHit
);
    // src is known not to be RNONE past the second branch, so a stage
    // whose dst is RNONE can never match below.
    always_comb begin
        val    = rfVal;
        fwdHit = 1'b0;
        if (useValP) begin
            val = valP;
        end else if (src == RNONE) begin
            val = '0;
        end else if (src == eDstE) begin
            val    = eValE;
            fwdHit = 1'b1;
        end else if (src == mDstM) begin
            val    = mValM;
            fwdHit = 1'b1;
        end else if (src == mDstE) begin
            val    = mValE;
            fwdHit = 1'b1;
        end else if (src == wDstM) begin
            val    = wValM;
            fwdHit = 1'b1;
        end else if (src == wDstE) begin
            val    = wValE;
            fwdHit = 1'b1;
        end
    end
endmodule

module decode_fwd_stage #(
    parameter int                  DATA_WID = 32,
    parameter int                  ADDR_WID = 4,
    parameter logic [ADDR_WID-1:0] RNONE    = 4'hF
) (
    input  logic                  CLK,
    input  logic                  RST,
    decode_fwd_stage_if.slave     bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]           ld_use_cnt,
    output logic [31:0]           fwd_cnt
`endif
);
    localparam int NUM_OPS = 2;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_POPL   = 4'hB;

    typedef struct packed {
        logic                valid;
        logic [3:0]          icode;
        logic [3:0]          ifun;
        logic [DATA_WID-1:0] valC;
        logic [DATA_WID-1:0] valA;
        logic [DATA_WID-1:0] valB;
        logic [ADDR_WID-1:0] dstE;
        logic [ADDR_WID-1:0] dstM;
        logic [ADDR_WID-1:0] srcA;
        logic [ADDR_WID-1:0] srcB;
    } eReg_t;

    function automatic eReg_t bubble();
        eReg_t b;
        b       = '0;
        b.icode = I_NOP;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.srcA  = RNONE;
        b.srcB  = RNONE;
        return b;
    endfunction

    eReg_t eReg;
    eReg_t dNext;

    logic [NUM_OPS-1:0][ADDR_WID-1:0] opSrc;
    logic [NUM_OPS-1:0][DATA_WID-1:0] opRf;
    logic [NUM_OPS-1:0][DATA_WID-1:0] opVal;
    logic [NUM_OPS-1:0]               opUseValP;
    logic [NUM_OPS-1:0]               opFwd;
    logic                             ldUse;

    assign bus.srcA = bus.D_srcA;
    assign bus.srcB = bus.D_srcB;

    // Index 0 is operand A (takes valP for CALL/JXX), index 1 is operand B.
    assign opSrc     = {bus.D_srcB, bus.D_srcA};
    assign opRf      = {bus.rf_valB, bus.rf_valA};
    assign opUseValP = {1'b0, (bus.D_icode == I_CALL) || (bus.D_icode == I_JXX)};

    for (genvar g = 0; g < NUM_OPS; g++) begin : gOp
        decode_fwd_mux #(
            .DATA_WID (DATA_WID),
            .ADDR_WID (ADDR_WID),
            .RNONE    (RNONE)
        ) uMux (
            .useValP (opUseValP[g]),
            .valP    (bus.D_valP),
            .src     (opSrc[g]),
            .rfVal   (opRf[g]),
            .eDstE   (bus.e_dstE),
            .eValE   (bus.e_valE),
            .mDstM   (bus.M_dstM),
            .mValM   (bus.m_valM),
            .mDstE   (bus.M_dstE),
            .mValE   (bus.M_valE),
            .wDstM   (bus.W_dstM),
            .wValM   (bus.W_valM),
            .wDstE   (bus.W_dstE),
            .wValE   (bus.W_valE),
            .val     (opVal[g]),
            .fwdHit  (opFwd[g])
        );
    end

    // Load in E whose result D needs now: the value only exists after the M stage.
    assign ldUse = bus.D_valid && eReg.valid &&
                   ((eReg.icode == I_MRMOVL) || (eReg.icode == I_POPL)) &&
                   (eReg.dstM != RNONE) &&
                   ((eReg.dstM == bus.D_srcA) || (eReg.dstM == bus.D_srcB));
    assign bus.ld_use_stall = ldUse;

    always_comb begin
        dNext       = '0;
        dNext.valid = bus.D_valid;
        dNext.icode = bus.D_icode;
        dNext.ifun  = bus.D_ifun;
        dNext.valC  = bus.D_valC;
        dNext.valA  = opVal[0];
        dNext.valB  = opVal[1];
        dNext.dstE  = bus.D_dstE;
        dNext.dstM  = bus.D_dstM;
        dNext.srcA  = bus.D_srcA;
        dNext.srcB  = bus.D_srcB;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            eReg <= bubble();
        else if (bus.E_hold)
            eReg <= eReg;
        else if (bus.E_flush || ldUse)
            eReg <= bubble();
        else
            eReg <= dNext;
    end

    assign bus.E_valid = eReg.valid;
    assign bus.E_icode = eReg.icode;
    assign bus.E_ifun  = eReg.ifun;
    assign bus.E_valC  = eReg.valC;
    assign bus.E_valA  = eReg.valA;
    assign bus.E_valB  = eReg.valB;
    assign bus.E_dstE  = eReg.dstE;
    assign bus.E_dstM  = eReg.dstM;
    assign bus.E_srcA  = eReg.srcA;
    assign bus.E_srcB  = eReg.srcB;

`ifdef DECODE_PERF_CNT_EN
    // Stalls masked by E_hold are not counted: the bubble they request never lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_use_cnt <= '0;
            fwd_cnt    <= '0;
        end else begin
            if (ldUse && !bus.E_hold && (ld_use_cnt != '1))
                ld_use_cnt <= ld_use_cnt + 32'd1;
            if (bus.D_valid && (|opFwd) && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_fwd_stage.sv
// Self-checking bench for decode_fwd_stage: directed scenarios plus random
// cycles against a priority-list operand model and a stage-level E register model.
module tb_decode_fwd_stage;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    decode_fwd_stage_if #(.DATA_WID(32), .ADDR_WID(4)) bus ();

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] ld_use_cnt, fwd_cnt;
    decode_fwd_stage dut (.CLK(CLK), .RST(RST), .bus(bus), .ld_use_cnt(ld_use_cnt), .fwd_cnt(fwd_cnt));
`else
    decode_fwd_stage dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    int nCmp = 0;
    int nErr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected E-stage register contents
    logic        mValid;
    logic [3:0]  mIcode, mIfun, mDstE, mDstM, mSrcA, mSrcB;
    logic [31:0] mValC, mValA, mValB;
    logic [31:0] mLdCnt, mFwdCnt;

    function automatic logic [31:0] refOperand(input logic [3:0] src, input logic isA, output logic hit);
        logic [3:0]  dst [5];
        logic [31:0] val [5];
        dst = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        val = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        hit = 1'b0;
        if (isA && (bus.D_icode == 4'h8 || bus.D_icode == 4'h7)) return bus.D_valP;
        if (src == 4'hF) return 32'h0;
        for (int i = 0; i < 5; i++)
            if (dst[i] == src) begin
                hit = 1'b1;
                return val[i];
            end
        return isA ? bus.rf_valA : bus.rf_valB;
    endfunction

    task automatic modelBubble();
        mValid = 1'b0; mIcode = 4'h1; mIfun = 4'h0;
        mValC = 0; mValA = 0; mValB = 0;
        mDstE = 4'hF; mDstM = 4'hF; mSrcA = 4'hF; mSrcB = 4'hF;
    endtask

    // Check at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        logic        expStall, hitA, hitB;
        logic [31:0] opA, opB;
        @(negedge CLK);
        expStall = bus.D_valid && mValid && (mIcode == 4'h5 || mIcode == 4'hB) &&
                   mDstM != 4'hF && (mDstM == bus.D_srcA || mDstM == bus.D_srcB);
        opA = refOperand(bus.D_srcA, 1'b1, hitA);
        opB = refOperand(bus.D_srcB, 1'b0, hitB);
        chk("srcA", 64'(bus.srcA), 64'(bus.D_srcA));
        chk("srcB", 64'(bus.srcB), 64'(bus.D_srcB));
        chk("ld_use_stall", 64'(bus.ld_use_stall), 64'(expStall));
        chk("E_ctl", 64'({bus.E_valid, bus.E_icode, bus.E_ifun}), 64'({mValid, mIcode, mIfun}));
        chk("E_valC", 64'(bus.E_valC), 64'(mValC));
        chk("E_valA", 64'(bus.E_valA), 64'(mValA));
        chk("E_valB", 64'(bus.E_valB), 64'(mValB));
        chk("E_regs", 64'({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}),
            64'({mDstE, mDstM, mSrcA, mSrcB}));
`ifdef DECODE_PERF_CNT_EN
        chk("ld_use_cnt", 64'(ld_use_cnt), 64'(mLdCnt));
        chk("fwd_cnt", 64'(fwd_cnt), 64'(mFwdCnt));
`endif
        @(posedge CLK);
        if (RST) begin
            modelBubble();
            mLdCnt = 0; mFwdCnt = 0;
        end else begin
            if (expStall && !bus.E_hold && mLdCnt != 32'hFFFFFFFF) mLdCnt++;
            if (bus.D_valid && (hitA || hitB) && mFwdCnt != 32'hFFFFFFFF) mFwdCnt++;
            if (bus.E_hold) ;
            else if (bus.E_flush || expStall) modelBubble();
            else begin
                mValid = bus.D_valid; mIcode = bus.D_icode; mIfun = bus.D_ifun;
                mValC = bus.D_valC; mValA = opA; mValB = opB;
                mDstE = bus.D_dstE; mDstM = bus.D_dstM;
                mSrcA = bus.D_srcA; mSrcB = bus.D_srcB;
            end
        end
        #1;
    endtask

    task automatic clearIn();
        RST = 1'b0;
        bus.D_valid = 1'b0; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
        bus.D_valC = 0; bus.D_valP = 0;
        bus.D_srcA = 4'hF; bus.D_srcB = 4'hF; bus.D_dstE = 4'hF; bus.D_dstM = 4'hF;
        bus.rf_valA = 0; bus.rf_valB = 0;
        bus.e_dstE = 4'hF; bus.e_valE = 0; bus.M_dstM = 4'hF; bus.m_valM = 0;
        bus.M_dstE = 4'hF; bus.M_valE = 0; bus.W_dstM = 4'hF; bus.W_valM = 0;
        bus.W_dstE = 4'hF; bus.W_valE = 0;
        bus.E_hold = 1'b0; bus.E_flush = 1'b0;
    endtask

    function automatic logic [3:0] rndReg();
        logic [3:0] r;
        r = 4'($urandom_range(0, 6));
        return (r > 4'd4) ? 4'hF : r;
    endfunction

    function automatic logic [3:0] rndIcode();
        logic [3:0] tbl [8];
        tbl = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB, 4'h5};
        return tbl[$urandom_range(0, 7)];
    endfunction

    logic [31:0] savedA;

    initial begin
        modelBubble();
        mLdCnt = 0; mFwdCnt = 0;
        clearIn();

        // Reset
        RST = 1'b1;
        cycle(); cycle();
        RST = 1'b0;
        chk("rst_valid", 64'(bus.E_valid), 64'(1'b0));
        chk("rst_icode", 64'(bus.E_icode), 64'(4'h1));
        chk("rst_dst", 64'({bus.E_dstE, bus.E_dstM}), 64'(8'hFF));
        chk("rst_valA", 64'(bus.E_valA), 64'(32'h0));

        // e beats M on the same source
        bus.D_valid = 1'b1; bus.D_icode = 4'h6; bus.D_srcA = 4'd2; bus.D_srcB = 4'd3;
        bus.e_dstE = 4'd3; bus.e_valE = 32'h55; bus.M_dstE = 4'd3; bus.M_valE = 32'h77;
        bus.rf_valA = 32'h10;
        cycle();
        chk("add_valA", 64'(bus.E_valA), 64'(32'h10));
        chk("add_valB", 64'(bus.E_valB), 64'(32'h55));

        // Load-use: one bubble, then forward from m_valM
        clearIn();
        bus.D_valid = 1'b1; bus.D_icode = 4'h5; bus.D_dstM = 4'd4;
        cycle();
        bus.D_icode = 4'h6; bus.D_dstM = 4'hF; bus.D_srcB = 4'd4; bus.rf_valB = 32'h1111;
        #1 chk("lu_stall", 64'(bus.ld_use_stall), 64'(1'b1));
        cycle();
        chk("lu_bubble", 64'(bus.E_valid), 64'(1'b0));
        bus.M_dstM = 4'd4; bus.m_valM = 32'hABCD;
        #1 chk("lu_clear", 64'(bus.ld_use_stall), 64'(1'b0));
        cycle();
        chk("lu_fwd", 64'(bus.E_valB), 64'(32'hABCD));

        // CALL takes valP; RNONE source reads as zero otherwise
        clearIn();
        bus.D_valid = 1'b1; bus.D_icode = 4'h8; bus.D_valP = 32'h20; bus.rf_valA = 32'h99;
        cycle();
        chk("call_valA", 64'(bus.E_valA), 64'(32'h20));
        bus.D_icode = 4'h6;
        cycle();
        chk("rnone_valA", 64'(bus.E_valA), 64'(32'h0));

        // Hold three cycles, then flush
        bus.D_icode = 4'h2; bus.D_srcA = 4'd1; bus.rf_valA = 32'h4242;
        cycle();
        savedA = bus.E_valA;
        bus.E_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rf_valA = $urandom; bus.D_icode = rndIcode();
            cycle();
            chk("hold_valA", 64'(bus.E_valA), 64'(32'h4242));
        end
        bus.E_hold = 1'b0; bus.E_flush = 1'b1;
        cycle();
        chk("flush_valid", 64'(bus.E_valid), 64'(1'b0));
        chk("flush_icode", 64'(bus.E_icode), 64'(4'h1));

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            RST = ($urandom_range(0, 59) == 0);
            bus.D_valid = ($urandom_range(0, 4) != 0);
            bus.D_icode = rndIcode(); bus.D_ifun = 4'($urandom);
            bus.D_valC = $urandom; bus.D_valP = $urandom;
            bus.D_srcA = rndReg(); bus.D_srcB = rndReg();
            bus.D_dstE = rndReg(); bus.D_dstM = rndReg();
            bus.rf_valA = $urandom; bus.rf_valB = $urandom;
            bus.e_dstE = rndReg(); bus.e_valE = $urandom;
            bus.M_dstM = rndReg(); bus.m_valM = $urandom;
            bus.M_dstE = rndReg(); bus.M_valE = $urandom;
            bus.W_dstM = rndReg(); bus.W_valM = $urandom;
            bus.W_dstE = rndReg(); bus.W_valE = $urandom;
            bus.E_hold = ($urandom_range(0, 5) == 0);
            bus.E_flush = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Reset mid-operation clears everything on one edge
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("rst2_valid", 64'(bus.E_valid), 64'(1'b0));
`ifdef DECODE_PERF_CNT_EN
        chk("rst2_cnt", 64'({ld_use_cnt, fwd_cnt}), 64'(0));
`endif
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
